mandel_dispatcher: RTL

//  Work scheduler between the Mandelbrot engine array and the framebuffer write port inside top_common.

---
 rtl/mandel_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/mandel_dispatcher.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mandel_pkg.sv
// Shared types and default sizing for the Mandelbrot work dispatcher.
//   fsm_state_t  : frame sequencing states
//   DEF_*        : default frame geometry, engine count and result width
//   addr_t       : framebuffer address at the default geometry
package mandel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } fsm_state_t;

    localparam int DEF_NUM_ENGINES = 8;
    localparam int DEF_WIDTH       = 1280;
    localparam int DEF_HEIGHT      = 720;
    localparam int DEF_DATA_BITS   = 4;
    localparam int DEF_DIM_BITS    = $clog2(DEF_WIDTH - 1);
    localparam int DEF_ADDR_BITS   = 2 * DEF_DIM_BITS;

    typedef logic [DEF_ADDR_BITS-1:0] addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk_calc    in   clock
//   reset_n     in   async active-low reset, pointer returns to 0
//   req         in   N request lines
//   grant       out  one-hot grant (combinational), zero when no request
//   grant_valid out  a grant is being issued this cycle
// The pointer names the highest-priority index; after a grant it moves to
// granted index + 1 so the winner drops to lowest priority.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk_calc,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;

    logic [PTR_BITS-1:0] ptr;
    logic [PTR_BITS-1:0] ptr_nxt;

    // First pass looks at indices at or above the pointer, second pass
    // wraps around to the indices below it.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        ptr_nxt     = ptr;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[i] && (i >= int'(ptr))) begin
                grant[i]    = 1'b1;
                grant_valid = 1'b1;
                ptr_nxt     = (i == N - 1) ? '0 : PTR_BITS'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[i]) begin
                grant[i]    = 1'b1;
                grant_valid = 1'b1;
                ptr_nxt     = (i == N - 1) ? '0 : PTR_BITS'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_calc or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mandel_dispatcher.sv
// Work scheduler between the Mandelbrot engine array and the framebuffer
// write port. Walks the frame in raster order, launches one pixel per cycle
// on the lowest free engine, remembers each engine's pixel address, and
// drains finished results round-robin onto the single write port.
//   clk_calc    in   sole clock
//   reset_n     in   async active-low reset (engines share it)
//   start       in   pulse: render a new frame (only honoured in IDLE)
//   busy        out  frame in progress (DISPATCH or DRAIN)
//   done        out  one-cycle pulse after the last pixel is written
//   eng_start   out  per-engine launch strobe, registered
//   eng_x/eng_y out  pixel coordinates, valid with eng_start
//   eng_valid   in   per-engine result ready, held until acked
//   eng_result  in   packed results, engine i at [i*DATA_BITS +: DATA_BITS]
//   eng_ack     out  per-engine accept strobe
//   wr_en/wr_addr/wr_data out  framebuffer write port
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; counters at pixel (0,0)
// DISPATCH | launching pixels on free engines, collecting results
// DRAIN    | all pixels launched, waiting for the last results
// DONE     | one cycle, last write committed, done asserted
module mandel_dispatcher
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int DIM_BITS    = $clog2(WIDTH - 1)
) (
    input  logic                           clk_calc,
    input  logic                           reset_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [DIM_BITS-1:0]            eng_x,
    output logic [DIM_BITS-1:0]            eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_valid,
    input  logic [NUM_ENGINES*DATA_BITS-1:0] eng_result,
    output logic [NUM_ENGINES-1:0]         eng_ack,
    output logic                           wr_en,
    output logic [2*DIM_BITS-1:0]          wr_addr,
    output logic [DATA_BITS-1:0]           wr_data
);

    localparam int ADDR_BITS = 2 * DIM_BITS;

    fsm_state_t state, state_nxt;

    logic [DIM_BITS-1:0]    x_cnt, y_cnt;
    logic [ADDR_BITS-1:0]   addr_cnt;
    logic [NUM_ENGINES-1:0] busy_mask;
    logic [NUM_ENGINES-1:0] free_vec;
    logic [NUM_ENGINES-1:0] issue_vec;
    logic [NUM_ENGINES-1:0] req;
    logic [NUM_ENGINES-1:0] grant;
    logic                   free_found;
    logic                   issue;
    logic                   last_pixel;
    logic                   grant_valid;
    logic [ADDR_BITS-1:0]   tag [NUM_ENGINES];
    logic [ADDR_BITS-1:0]   sel_tag;
    logic [DATA_BITS-1:0]   sel_data;

    // Lowest-index engine with its busy bit clear.
    always_comb begin
        free_found = 1'b0;
        free_vec   = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (!busy_mask[i] && !free_found) begin
                free_found  = 1'b1;
                free_vec[i] = 1'b1;
            end
        end
    end

    assign last_pixel = (x_cnt == DIM_BITS'(WIDTH - 1)) &&
                        (y_cnt == DIM_BITS'(HEIGHT - 1));

    // The first pixel is launched on the same edge that accepts start, so
    // its eng_start appears in the cycle right after start is sampled.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    issue     = free_found;
                    state_nxt = (free_found && last_pixel) ? ST_DRAIN : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                issue = free_found;
                if (free_found && last_pixel) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((busy_mask == '0) && !grant_valid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign issue_vec = {NUM_ENGINES{issue}} & free_vec;
    assign busy      = (state == ST_DISPATCH) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

    // Results from engines we never launched (busy bit clear) are ignored.
    assign req = eng_valid & busy_mask;

    rr_arbiter #(
        .N (NUM_ENGINES)
    ) u_arb (
        .clk_calc    (clk_calc),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (grant[i]) begin
                sel_tag  = sel_tag  | tag[i];
                sel_data = sel_data | eng_result[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk_calc or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Running address replaces y*WIDTH + x; everything rewinds after the
    // last pixel so IDLE always holds (0,0).
    always_ff @(posedge clk_calc or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (issue) begin
            if (last_pixel) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                addr_cnt <= '0;
            end else begin
                addr_cnt <= addr_cnt + ADDR_BITS'(1);
                if (x_cnt == DIM_BITS'(WIDTH - 1)) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + DIM_BITS'(1);
                end else begin
                    x_cnt <= x_cnt + DIM_BITS'(1);
                end
            end
        end
    end

    // Busy bit drops on the grant edge, i.e. while eng_ack is high, so the
    // earliest relaunch strobe lands in the cycle after the ack.
    always_ff @(posedge clk_calc or negedge reset_n) begin
        if (!reset_n) begin
            busy_mask <= '0;
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            eng_ack   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                tag[i] <= '0;
            end
        end else begin
            busy_mask <= (busy_mask | issue_vec) & ~grant;
            eng_start <= issue_vec;
            if (issue) begin
                eng_x <= x_cnt;
                eng_y <= y_cnt;
            end
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (issue_vec[i]) begin
                    tag[i] <= addr_cnt;
                end
            end
            eng_ack <= grant;
            wr_en   <= grant_valid;
            wr_addr <= sel_tag;
            wr_data <= sel_data;
        end
    end

endmodule
